// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared op codes and flag indices for the SAP register bank
package sap_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  // Bit positions when a controller packs the flags into one vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/sap_alu_unary.sv
// rtl/sap_alu_unary.sv - combinational single-operand ALU (load/inc/dec/shift/rotate)
module sap_alu_unary
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  always_comb begin
    result_o = operand_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_LD: begin
        result_o = bus_i;
        carry_o  = 1'b0;
      end
      OP_INC: begin
        result_o = operand_i + 1'b1;
        carry_o  = &operand_i;
      end
      OP_DEC: begin
        // Carry acts as borrow on the 0 -> all-ones wrap
        result_o = operand_i - 1'b1;
        carry_o  = ~|operand_i;
      end
      OP_SHL: begin
        result_o = {operand_i[WIDTH-2:0], 1'b0};
        carry_o  = operand_i[WIDTH-1];
      end
      OP_SHR: begin
        result_o = {1'b0, operand_i[WIDTH-1:1]};
        carry_o  = operand_i[0];
      end
      OP_ROL: begin
        result_o = {operand_i[WIDTH-2:0], operand_i[WIDTH-1]};
        carry_o  = operand_i[WIDTH-1];
      end
      OP_ROR: begin
        result_o = {operand_i[0], operand_i[WIDTH-1:1]};
        carry_o  = operand_i[0];
      end
      default: begin
        result_o = operand_i;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sap_reg_bank.sv
// rtl/sap_reg_bank.sv - SAP register array with in-place unary ops and Z/S/C flags
module sap_reg_bank
  import sap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             op_i,
  input  logic [SEL_W-1:0]       op_sel_i,
  input  logic [WIDTH-1:0]       bus_i,
  input  logic [SEL_W-1:0]       rd_sel_i,
  output logic [WIDTH-1:0]       bus_o,
  output logic [NREGS*WIDTH-1:0] parallel_o,
  output logic                   zero_o,
  output logic                   sign_o,
  output logic                   carry_o
);

  localparam logic [SEL_W:0] NREGS_L = (SEL_W+1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;

  logic             op_valid;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // Out-of-range selects only exist when NREGS is not a power of two
  assign op_valid = ({1'b0, op_sel_i} < NREGS_L) && (op_i != OP_NOP);

  always_comb begin
    operand = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (op_sel_i == SEL_W'(k)) operand = regs_q[k];
    end
  end

  sap_alu_unary #(.WIDTH(WIDTH)) u_alu (
    .op_i      (op_i),
    .operand_i (operand),
    .bus_i     (bus_i),
    .result_o  (alu_result),
    .carry_o   (alu_carry)
  );

  always_comb begin
    for (int k = 0; k < NREGS; k++) regs_d[k] = regs_q[k];
    zero_d  = zero_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    if (op_valid) begin
      for (int k = 0; k < NREGS; k++) begin
        if (op_sel_i == SEL_W'(k)) regs_d[k] = alu_result;
      end
      zero_d  = ~|alu_result;
      sign_d  = alu_result[WIDTH-1];
      carry_d = alu_carry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      zero_q  <= 1'b1;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    bus_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (rd_sel_i == SEL_W'(k)) bus_o = regs_q[k];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_par
    assign parallel_o[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign zero_o  = zero_q;
  assign sign_o  = sign_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_sap_reg_bank.sv
// tb/tb_sap_reg_bank.sv - directed self-checking bench for sap_reg_bank
module tb_sap_reg_bank;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  op_i;
  logic [1:0]  op_sel_i;
  logic [7:0]  bus_i;
  logic [1:0]  rd_sel_i;
  logic [7:0]  bus_o;
  logic [31:0] parallel_o;
  logic        zero_o, sign_o, carry_o;

  int checks = 0;
  int errors = 0;

  sap_reg_bank #(.WIDTH(8), .NREGS(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .op_i       (op_i),
    .op_sel_i   (op_sel_i),
    .bus_i      (bus_i),
    .rd_sel_i   (rd_sel_i),
    .bus_o      (bus_o),
    .parallel_o (parallel_o),
    .zero_o     (zero_o),
    .sign_o     (sign_o),
    .carry_o    (carry_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one op for one edge, then return the inputs to NOP
  task automatic do_op(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] data);
    op_i     = op;
    op_sel_i = sel;
    bus_i    = data;
    @(posedge clk_i);
    #1;
    op_i  = 3'b000;
    bus_i = 8'h00;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, zero_o, sign_o, carry_o};
  endfunction

  initial begin
    rst_i    = 1'b1;
    op_i     = 3'b000;
    op_sel_i = 2'd0;
    bus_i    = 8'h00;
    rd_sel_i = 2'd0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset_regs", parallel_o, 32'h0000_0000);
    check("reset_flags", flags(), 32'h4);

    do_op(3'b001, 2'd2, 8'hA5);
    check("load_a5_regs", parallel_o, 32'h00A5_0000);
    check("load_a5_flags", flags(), 32'h2);

    do_op(3'b001, 2'd0, 8'hFF);
    check("load_ff_flags", flags(), 32'h2);
    do_op(3'b010, 2'd0, 8'h00);
    check("inc_wrap_reg", parallel_o, 32'h00A5_0000);
    check("inc_wrap_flags", flags(), 32'h5);
    do_op(3'b000, 2'd0, 8'h00);
    check("nop_flags", flags(), 32'h5);
    check("nop_regs", parallel_o, 32'h00A5_0000);

    do_op(3'b011, 2'd1, 8'h00);
    check("dec_borrow_reg", parallel_o, 32'h00A5_FF00);
    check("dec_borrow_flags", flags(), 32'h3);
    do_op(3'b011, 2'd1, 8'h00);
    check("dec2_reg", parallel_o, 32'h00A5_FE00);
    check("dec2_flags", flags(), 32'h2);

    do_op(3'b001, 2'd3, 8'h81);
    do_op(3'b100, 2'd3, 8'h00);
    check("shl_reg", parallel_o, 32'h02A5_FE00);
    check("shl_flags", flags(), 32'h1);
    do_op(3'b111, 2'd3, 8'h00);
    check("ror1_reg", parallel_o, 32'h01A5_FE00);
    check("ror1_flags", flags(), 32'h0);
    do_op(3'b111, 2'd3, 8'h00);
    check("ror2_reg", parallel_o, 32'h80A5_FE00);
    check("ror2_flags", flags(), 32'h3);
    do_op(3'b101, 2'd3, 8'h00);
    check("shr_reg", parallel_o, 32'h40A5_FE00);
    check("shr_flags", flags(), 32'h0);
    do_op(3'b110, 2'd3, 8'h00);
    check("rol_reg", parallel_o, 32'h80A5_FE00);
    check("rol_flags", flags(), 32'h2);
    do_op(3'b100, 2'd3, 8'h00);
    check("shl_zero_flags", flags(), 32'h5);

    do_op(3'b001, 2'd3, 8'h40);
    do_op(3'b001, 2'd2, 8'h10);
    op_i     = 3'b010;
    op_sel_i = 2'd2;
    rd_sel_i = 2'd2;
    #1;
    check("rdw_before", {24'd0, bus_o}, 32'h10);
    rd_sel_i = 2'd3;
    #1;
    check("rdw_other_before", {24'd0, bus_o}, 32'h40);
    rd_sel_i = 2'd2;
    @(posedge clk_i);
    #1;
    op_i = 3'b000;
    check("rdw_after", {24'd0, bus_o}, 32'h11);
    rd_sel_i = 2'd3;
    #1;
    check("rdw_other_after", {24'd0, bus_o}, 32'h40);
    rd_sel_i = 2'd1;
    #1;
    check("rd_reg1", {24'd0, bus_o}, 32'hFE);
    check("rdw_regs", parallel_o, 32'h4011_FE00);

    do_op(3'b001, 2'd0, 8'h05);
    check("load5_regs", parallel_o, 32'h4011_FE05);
    rst_i = 1'b1;
    do_op(3'b010, 2'd0, 8'h00);
    rst_i = 1'b0;
    check("rst_mid_regs", parallel_o, 32'h0000_0000);
    check("rst_mid_flags", flags(), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_reg_bank.md
Name: sap_reg_bank

Overview:
- Parametrised register bank for the SAP-2/SAP-3 datapath; replaces the individual A, B, TMP, C and output registers with one block.
- Holds NREGS registers of WIDTH bits.
- Each cycle one register can be loaded from the bus or modified in place (increment, decrement, shift, rotate).
- Registered Z/S/C flags are produced for the controller's conditional jumps.
- Any register can be driven onto the bus; all registers are always visible in parallel for the output/display logic.

Parameters:
- WIDTH, 8, bit width of each register and of the bus.
- NREGS, 4, number of registers (2..16).
- SEL_W, $clog2(NREGS), select-field width (derived; do not override).

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset, sampled on the rising edge of clk_i.
- op_i  in  3  operation code, applied to register op_sel_i.
- op_sel_i  in  SEL_W  target register of op_i.
- bus_i  in  WIDTH  bus data for LOAD.
- rd_sel_i  in  SEL_W  register driven onto bus_o.
- bus_o  out  WIDTH  contents of register rd_sel_i (combinational read).
- parallel_o  out  NREGS*WIDTH  all registers flattened; register k at bits [k*WIDTH +: WIDTH].
- zero_o  out  1  Z flag: result of the last flag-updating op was 0.
- sign_o  out  1  S flag: MSB of the last flag-updating result.
- carry_o  out  1  C flag, as defined per op below.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All registers become 0.
  - zero_o=1, sign_o=0, carry_o=0.
  - Reset overrides any op in the same cycle, including mid-sequence ops.
- Op encoding. r = register[op_sel_i]; all results are truncated to WIDTH.
  - 000 NOP: no change; flags hold.
  - 001 LOAD: r <= bus_i; C <= 0.
  - 010 INC: r <= r+1; C <= 1 iff r was all-ones (wraps to 0).
  - 011 DEC: r <= r-1; C <= 1 iff r was 0 (wraps to all-ones; borrow).
  - 100 SHL: r <= {r[WIDTH-2:0],0}; C <= r[WIDTH-1].
  - 101 SHR (logical): r <= {0,r[WIDTH-1:1]}; C <= r[0].
  - 110 ROL: r <= {r[WIDTH-2:0],r[WIDTH-1]}; C <= r[WIDTH-1].
  - 111 ROR: r <= {r[0],r[WIDTH-1:1]}; C <= r[0].
- Flags:
  - Every non-NOP op updates Z and S from the new value of r, in the same edge as the register write.
  - Latency from op to new register value and new flags: 1 cycle.
- Ops on an out-of-range select (op_sel_i >= NREGS, only possible when NREGS is not a power of 2) are ignored entirely: no register change, flags hold.
- Only register op_sel_i may change in a cycle; all other registers hold.
- bus_o:
  - Pure combinational mux of the current register state.
  - Reading the register being written in the same cycle returns the old value; the new value appears after the edge.
  - rd_sel_i >= NREGS drives 0.
- parallel_o reflects register state (registered outputs, no combinational path from op_i or bus_i).
- No X propagation: every register and flag has a defined value from the first reset onward.

Decomposition:
- Shared package sap_pkg:
  - op-code localparams OP_NOP..OP_ROR (3-bit);
  - flag-index constants FLAG_Z, FLAG_S, FLAG_C for controllers that pack flags into a vector.
- One natural sub-module, sap_alu_unary:
  - purely combinational;
  - inputs: op, operand, bus_i;
  - outputs: result, carry.
  - Keeps the sequential bank small and lets SAP-3 reuse the unit.
- The bank itself holds the register array, write-enable decode and flag registers.

Test Plan (WIDTH=8, NREGS=4):
- Reset and load:
  - Assert rst_i for 1 cycle -> parallel_o=0, Z=1, S=0, C=0.
  - Then LOAD reg2 with bus_i=8'hA5 -> next cycle parallel_o[23:16]=8'hA5, Z=0, S=1, C=0; other registers remain 0.
- INC wrap: LOAD reg0=8'hFF, then INC reg0 -> reg0=8'h00, Z=1, S=0, C=1. A following NOP leaves all flags unchanged.
- DEC borrow: reg1=0, DEC reg1 -> reg1=8'hFF, Z=0, S=1, C=1. A second DEC -> 8'hFE, C=0.
- Shift/rotate on reg3=8'b1000_0001:
  - SHL -> 8'b0000_0010, C=1;
  - then ROR -> 8'b0000_0001, C=0;
  - then ROR -> 8'b1000_0000, C=1;
  - then SHR -> 8'b0100_0000, C=0.
- Read-during-write:
  - With reg2=8'h10, INC reg2 and rd_sel_i=2 in the same cycle -> bus_o=8'h10 before the edge, 8'h11 after.
  - rd_sel_i=3 is unaffected.
- Reset mid-operation: issue INC reg0 with rst_i=1 in the same cycle -> reg0=0 and flags at reset values; the INC takes no effect.
